miriscv_lsu_pipe: RTL and testbench

Parametrised load/store unit that replaces the purely combinational LSU with a registered request/grant/response memory handshake. It sits between the core's execute stage and the data memory or bus port. It adds offset-correct sub-word load extraction, XLEN=64 support, misalignment and bus-error reporting, and a stall that tracks the real memory latency.

---
 rtl/miriscv_lsu_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_miriscv_lsu_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu_pipe.sv
// Load/store unit with a registered req/gnt/rvalid memory handshake, sub-word extraction and XLEN=32/64.
// Optional response watchdog and late-response drop are enabled by defining LSU_RESP_TIMEOUT_EN.
module miriscv_lsu_pipe #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [2:0]          lsu_size_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]     lsu_data_i,
    output logic                lsu_stall_req_o,
    output logic [XLEN-1:0]     lsu_data_o,
    output logic                lsu_misalign_o,
    output logic                lsu_err_o,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    input  logic                data_err_i,
    input  logic [XLEN-1:0]     data_rdata_i,
    output logic                data_we_o,
    output logic [XLEN/8-1:0]   data_be_o,
    output logic [ADDR_W-1:0]   data_addr_o,
    output logic [XLEN-1:0]     data_wdata_o
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("miriscv_lsu_pipe: XLEN must be 32 or 64");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("miriscv_lsu_pipe: TIMEOUT_CYC must be in 1..65535");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [XLEN-1:0]     wdata_q;
    logic                we_q;
    logic [2:0]          size_q;
    logic [OFF_W-1:0]    off_q;
    logic [XLEN-1:0]     rdata_q;
    logic                misalign_q;
    logic                err_q;
    logic                abort_q;

    logic                size_ok;
    logic                aligned;
    logic [BE_W-1:0]     mask;
    logic [BE_W-1:0]     be_d;
    logic [XLEN-1:0]     wdata_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [XLEN-1:0]     rdata_sh;
    logic [XLEN-1:0]     load_ext;
    logic                abort_w;
    logic                timeout_w;
    logic                drop_q;

`ifdef LSU_RESP_TIMEOUT_EN
    logic [15:0]         cnt_q;
    assign timeout_w = (cnt_q >= 16'(TIMEOUT_CYC - 1));
`else
    assign timeout_w = 1'b0;
    assign drop_q    = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        size_ok = 1'b0;
        aligned = 1'b0;
        mask    = '0;
        wdata_d = lsu_data_i;
        case (lsu_size_i)
            3'd0, 3'd1, 3'd2: size_ok = 1'b1;
            3'd3:             size_ok = (XLEN == 64);
            3'd4, 3'd5:       size_ok = !lsu_we_i;
            3'd6:             size_ok = !lsu_we_i && (XLEN == 64);
            default:          size_ok = 1'b0;
        endcase
        case (lsu_size_i[1:0])
            2'd0: begin
                aligned = 1'b1;
                mask    = BE_W'(1);
                wdata_d = {BE_W{lsu_data_i[7:0]}};
            end
            2'd1: begin
                aligned = !lsu_addr_i[0];
                mask    = BE_W'(3);
                wdata_d = {(XLEN/16){lsu_data_i[15:0]}};
            end
            2'd2: begin
                aligned = (lsu_addr_i[1:0] == 2'b00);
                mask    = BE_W'(15);
                wdata_d = {(XLEN/32){lsu_data_i[31:0]}};
            end
            default: begin
                aligned = (lsu_addr_i[2:0] == 3'b000);
                mask    = '1;
            end
        endcase
    end

    assign be_d   = mask << lsu_addr_i[OFF_W-1:0];
    assign addr_d = {lsu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        rdata_sh = data_rdata_i >> {off_q, 3'b000};
        case (size_q)
            3'd0:    load_ext = XLEN'($signed(rdata_sh[7:0]));
            3'd1:    load_ext = XLEN'($signed(rdata_sh[15:0]));
            3'd2:    load_ext = XLEN'($signed(rdata_sh[31:0]));
            3'd4:    load_ext = XLEN'(rdata_sh[7:0]);
            3'd5:    load_ext = XLEN'(rdata_sh[15:0]);
            3'd6:    load_ext = XLEN'(rdata_sh[31:0]);
            default: load_ext = rdata_sh;
        endcase
    end

    // A core that withdraws its request still lets the bus transfer finish; the result is dropped.
    assign abort_w = abort_q || !lsu_req_i;

    // NOTE: state is updated with non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
`ifdef LSU_RESP_TIMEOUT_EN
            cnt_q      <= '0;
            drop_q     <= 1'b0;
`endif
        end else begin
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef LSU_RESP_TIMEOUT_EN
            if (state_q == S_REQ || state_q == S_RSP) cnt_q <= cnt_q + 16'd1;
            if (drop_q && data_rvalid_i) drop_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (lsu_req_i && !drop_q) begin
                        if (size_ok && aligned) begin
                            addr_q  <= addr_d;
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            we_q    <= lsu_we_i;
                            size_q  <= lsu_size_i;
                            off_q   <= lsu_addr_i[OFF_W-1:0];
                            abort_q <= 1'b0;
                            state_q <= S_REQ;
`ifdef LSU_RESP_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end else begin
                            misalign_q <= 1'b1;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (!lsu_req_i) abort_q <= 1'b1;
                    if (data_gnt_i) begin
                        state_q <= S_RSP;
                    end else if (timeout_w) begin
                        state_q <= abort_w ? S_IDLE : S_DONE;
                        err_q   <= !abort_w;
                    end
                end
                S_RSP: begin
                    if (!lsu_req_i) abort_q <= 1'b1;
                    if (data_rvalid_i) begin
                        if (abort_w) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DONE;
                            if (data_err_i) begin
                                err_q   <= 1'b1;
                                rdata_q <= '0;
                            end else if (!we_q) begin
                                rdata_q <= load_ext;
                            end
                        end
                    end else if (timeout_w) begin
                        state_q <= abort_w ? S_IDLE : S_DONE;
                        err_q   <= !abort_w;
`ifdef LSU_RESP_TIMEOUT_EN
                        drop_q  <= 1'b1;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lsu_stall_req_o = lsu_req_i && (state_q != S_DONE);
    assign lsu_data_o      = rdata_q;
    assign lsu_misalign_o  = misalign_q;
    assign lsu_err_o       = err_q;
    assign data_req_o      = (state_q == S_REQ) && !rst_i;
    assign data_we_o       = we_q;
    assign data_be_o       = be_q;
    assign data_addr_o     = addr_q;
    assign data_wdata_o    = wdata_q;
endmodule

// File: tb/tb_miriscv_lsu_pipe.sv
// Scoreboard bench for miriscv_lsu_pipe: XLEN=32 instance with a delay-programmable memory, plus an XLEN=64 instance.
// Watchdog cases run only when LSU_RESP_TIMEOUT_EN is defined (TIMEOUT_CYC=8).
module tb_miriscv_lsu_pipe;
`ifdef LSU_RESP_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_data_i;
    logic        lsu_stall_req_o, lsu_misalign_o, lsu_err_o;
    logic [31:0] lsu_data_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
    logic [31:0] data_rdata_i, data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;

    logic        req64, stall64, mis64, err64, dreq64, rvalid64, we64_o;
    logic [2:0]  size64;
    logic [31:0] addr64, daddr64;
    logic [63:0] ldata64, rdata64, wdata64_o;
    logic [7:0]  be64;

    always #5 clk = ~clk;

    miriscv_lsu_pipe #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
        .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o),
        .lsu_misalign_o(lsu_misalign_o), .lsu_err_o(lsu_err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_err_i(data_err_i), .data_rdata_i(data_rdata_i), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o)
    );

    miriscv_lsu_pipe #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(TO_CYC)) dut64 (
        .clk(clk), .rst_i(rst_i),
        .lsu_req_i(req64), .lsu_we_i(1'b0), .lsu_size_i(size64),
        .lsu_addr_i(addr64), .lsu_data_i(64'h0),
        .lsu_stall_req_o(stall64), .lsu_data_o(ldata64),
        .lsu_misalign_o(mis64), .lsu_err_o(err64),
        .data_req_o(dreq64), .data_gnt_i(dreq64), .data_rvalid_i(rvalid64),
        .data_err_i(1'b0), .data_rdata_i(rdata64), .data_we_o(we64_o),
        .data_be_o(be64), .data_addr_o(daddr64), .data_wdata_o(wdata64_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        err;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Memory model for the 32-bit instance: grant after gnt_dly REQ cycles, respond rsp_dly cycles later.
    int          gnt_dly, rsp_dly, rsp_dly_g, gcnt, rcnt;
    logic [31:0] mem_rdata, rsp_data;
    logic        mem_err, rsp_err, pending;
    int          req_seen, req_while_pending;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;

    initial begin
        data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = '0;
        pending = 0; gcnt = 0; rcnt = 0; req_seen = 0; req_while_pending = 0;
        rsp_data = '0; rsp_err = 0; rsp_dly_g = 0;
        cap_be = '0; cap_addr = '0; cap_wdata = '0; cap_we = 0;
        forever begin
            @(posedge clk); #1;
            data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = '0;
            if (data_req_o) req_seen++;
            if (pending) begin
                if (data_req_o) req_while_pending++;
                if (rcnt == rsp_dly_g) begin
                    data_rvalid_i = 1; data_rdata_i = rsp_data; data_err_i = rsp_err; pending = 0;
                end else rcnt++;
            end else if (data_req_o) begin
                if (gcnt == gnt_dly) begin
                    data_gnt_i = 1; pending = 1; rcnt = 0; gcnt = 0;
                    rsp_data = mem_rdata; rsp_err = mem_err; rsp_dly_g = rsp_dly;
                    cap_be = data_be_o; cap_addr = data_addr_o; cap_wdata = data_wdata_o; cap_we = data_we_o;
                end else gcnt++;
            end else gcnt = 0;
        end
    end

    // Completion monitor: the DONE cycle is the one where a held request sees stall low.
    initial forever begin
        @(negedge clk);
        if (!rst_i && lsu_req_i && !lsu_stall_req_o) begin
            if (sb_q.size() == 0) check("unexpected_done", 1'b1, 1'b0);
            else begin
                mon_e = sb_q.pop_front();
                check("done_data", lsu_data_o, mon_e.data);
                check("done_misalign", lsu_misalign_o, mon_e.mis);
                check("done_err", lsu_err_o, mon_e.err);
            end
        end
    end

    // 64-bit memory: grant tied to request, response one cycle after grant.
    logic rv64_next;
    logic [7:0]  cap_be64;
    logic [31:0] cap_addr64;
    initial begin
        rvalid64 = 0; cap_be64 = '0; cap_addr64 = '0;
        forever begin
            @(negedge clk);
            rv64_next = dreq64;
            if (dreq64) begin cap_be64 = be64; cap_addr64 = daddr64; end
            @(posedge clk); #1;
            rvalid64 = rv64_next;
        end
    end

    task automatic acc(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                       input int gd, input int rd, input logic mis_exp, input logic err_exp,
                       input logic [31:0] data_exp, input int lat_exp);
        int cyc;
        int req_before;
        bit done;
        gnt_dly = gd; rsp_dly = rd; mem_rdata = rdata; mem_err = err;
        sb_q.push_back('{data: data_exp, mis: mis_exp, err: err_exp});
        req_before = req_seen;
        @(posedge clk); #1;
        lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_data_i = wdata; lsu_req_i = 1;
        cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (!lsu_stall_req_o) done = 1; else cyc++;
        end
        check("completion_in_bound", done, 1'b1);
        if (lat_exp >= 0) check("stall_cycles", cyc, lat_exp);
        if (mis_exp) check("misalign_no_bus_req", req_seen - req_before, 0);
        @(posedge clk); #1;
        lsu_req_i = 0;
        @(negedge clk);
        check("misalign_one_cycle", lsu_misalign_o, 1'b0);
        check("err_one_cycle", lsu_err_o, 1'b0);
    endtask

    task automatic acc64(input logic [2:0] size, input logic [31:0] addr, input logic [63:0] rdata,
                         input logic [63:0] exp, input logic [7:0] exp_be);
        int cyc;
        rdata64 = rdata;
        @(posedge clk); #1;
        size64 = size; addr64 = addr; req64 = 1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (stall64 && cyc < 50);
        check("x64_stall_release", stall64, 1'b0);
        check("x64_data", ldata64, exp);
        check("x64_be", cap_be64, exp_be);
        check("x64_addr", cap_addr64, {addr[31:3], 3'b000});
        @(posedge clk); #1;
        req64 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end

    logic        flags_seen;
    logic [31:0] last_data;
    int          cyc;

    initial begin
        rst_i = 1; lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_addr_i = 0; lsu_data_i = 0;
        req64 = 0; size64 = 0; addr64 = 0; rdata64 = 0;
        gnt_dly = 0; rsp_dly = 0; mem_rdata = 0; mem_err = 0;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        check("rst_stall", lsu_stall_req_o, 1'b0);
        check("rst_data", lsu_data_o, 32'h0);
        check("rst_misalign", lsu_misalign_o, 1'b0);
        check("rst_err", lsu_err_o, 1'b0);
        check("rst_data_req", data_req_o, 1'b0);
        check("rst_be", data_be_o, 4'h0);
        check("rst_addr", data_addr_o, 32'h0);
        check("rst_wdata", data_wdata_o, 32'h0);
        check("rst_we", data_we_o, 1'b0);
        check("rst_data64", ldata64, 64'h0);

        // Loads with earliest grant and response
        acc(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'hDEADBEEF, 3);
        check("lw_be", cap_be, 4'hF);
        check("lw_addr", cap_addr, 32'h100);
        check("lw_we", cap_we, 1'b0);
        acc(0, 3'd0, 32'h103, 0, 32'h80112233, 0, 0, 0, 0, 0, 32'hFFFFFF80, 3);
        check("lb_be", cap_be, 4'b1000);
        check("lb_addr", cap_addr, 32'h100);
        acc(0, 3'd4, 32'h103, 0, 32'h80112233, 0, 0, 0, 0, 0, 32'h00000080, 3);
        acc(0, 3'd1, 32'h102, 0, 32'h80112233, 0, 0, 0, 0, 0, 32'hFFFF8011, 3);
        check("lh_be", cap_be, 4'b1100);
        acc(0, 3'd5, 32'h100, 0, 32'hFFFF9234, 0, 0, 0, 0, 0, 32'h00009234, 3);
        check("lhu_be", cap_be, 4'b0011);

        // Stores leave lsu_data_o at the last load value
        acc(1, 3'd1, 32'h202, 32'h1234ABCD, 0, 0, 0, 0, 0, 0, 32'h00009234, 3);
        check("sh_be", cap_be, 4'b1100);
        check("sh_wdata", cap_wdata, 32'hABCDABCD);
        check("sh_we", cap_we, 1'b1);
        check("sh_addr", cap_addr, 32'h200);
        acc(1, 3'd0, 32'h201, 32'h0000005A, 0, 0, 1, 1, 0, 0, 32'h00009234, 5);
        check("sb_be", cap_be, 4'b0010);
        check("sb_wdata", cap_wdata, 32'h5A5A5A5A);
        acc(1, 3'd2, 32'h204, 32'hA5A50F0F, 0, 0, 0, 0, 0, 0, 32'h00009234, 3);
        check("sw_wdata", cap_wdata, 32'hA5A50F0F);
        check("sw_addr", cap_addr, 32'h204);

        // Misaligned and illegal sizes never reach the bus
        acc(0, 3'd2, 32'h101, 0, 0, 0, 0, 0, 1, 0, 32'h00009234, 1);
        acc(0, 3'd1, 32'h103, 0, 0, 0, 0, 0, 1, 0, 32'h00009234, 1);
        acc(0, 3'd3, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h00009234, 1);
        acc(0, 3'd7, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h00009234, 1);
        acc(1, 3'd4, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h00009234, 1);

        // Delayed grant with bus error, then a delayed response
        acc(0, 3'd2, 32'h108, 0, 32'h55555555, 1, 3, 0, 0, 1, 32'h00000000, 6);
        acc(0, 3'd2, 32'h104, 0, 32'h11223344, 0, 0, 2, 0, 0, 32'h11223344, 5);

        // Request withdrawn mid-transaction: bus completes, result discarded
        gnt_dly = 0; rsp_dly = 3; mem_rdata = 32'hCAFEF00D; mem_err = 0;
        @(posedge clk); #1;
        lsu_we_i = 0; lsu_size_i = 3'd2; lsu_addr_i = 32'h400; lsu_req_i = 1;
        @(posedge clk); #1;
        lsu_req_i = 0;
        flags_seen = 0;
        repeat (10) begin @(negedge clk); flags_seen |= lsu_err_o | lsu_misalign_o; end
        check("abort_flags", flags_seen, 1'b0);
        check("abort_data_kept", lsu_data_o, 32'h11223344);
        check("abort_back_idle", data_req_o, 1'b0);

        // Reset while waiting in RSP; the late response must be ignored
        gnt_dly = 0; rsp_dly = 4; mem_rdata = 32'h77777777; mem_err = 0;
        @(posedge clk); #1;
        lsu_size_i = 3'd2; lsu_addr_i = 32'h300; lsu_req_i = 1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!data_gnt_i && cyc < 20);
        check("rst_rsp_grant_seen", data_gnt_i, 1'b1);
        @(posedge clk); #2 rst_i = 1;
        @(posedge clk); #1 rst_i = 0; lsu_req_i = 0;
        @(negedge clk);
        check("rst_rsp_data", lsu_data_o, 32'h0);
        check("rst_rsp_stall", lsu_stall_req_o, 1'b0);
        check("rst_rsp_req", data_req_o, 1'b0);
        flags_seen = 0; last_data = 0;
        repeat (8) begin @(negedge clk); flags_seen |= lsu_err_o | lsu_misalign_o; last_data |= lsu_data_o; end
        check("late_rvalid_flags", flags_seen, 1'b0);
        check("late_rvalid_data", last_data, 32'h0);

        // Reset while in REQ drops data_req_o in the same cycle
        gnt_dly = 10; rsp_dly = 0;
        @(posedge clk); #1;
        lsu_size_i = 3'd2; lsu_addr_i = 32'h500; lsu_req_i = 1;
        @(posedge clk); #2 rst_i = 1;
        #1 check("rst_req_comb", data_req_o, 1'b0);
        @(posedge clk); #1 rst_i = 0; lsu_req_i = 0;
        @(negedge clk);
        check("rst_req_idle", data_req_o, 1'b0);

        acc(0, 3'd2, 32'h10C, 0, 32'h0BADCAFE, 0, 0, 0, 0, 0, 32'h0BADCAFE, 3);

`ifdef LSU_RESP_TIMEOUT_EN
        // Watchdog fires in RSP; the late response is dropped and the next load sees its own data
        acc(0, 3'd2, 32'h40, 0, 32'hBAD0BAD0, 0, 0, 20, 0, 1, 32'h0BADCAFE, 9);
        acc(0, 3'd2, 32'h0, 0, 32'h600DF00D, 0, 0, 0, 0, 0, 32'h600DF00D, -1);
        check("drop_no_req_while_pending", req_while_pending, 0);
`endif

        // XLEN=64 instance
        acc64(3'd3, 32'h8, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 8'hFF);
        acc64(3'd2, 32'hC, 64'h80000000_11111111, 64'hFFFFFFFF_80000000, 8'hF0);
        acc64(3'd6, 32'hC, 64'h80000000_11111111, 64'h00000000_80000000, 8'hF0);
        acc64(3'd0, 32'hF, 64'h7F00000000000000, 64'h000000000000007F, 8'h80);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
